// File: rtl/pic_pkg.sv
// Shared helpers for the PIC blocks: bit/number conversion and 8-bit rotations.
package pic_pkg;

  localparam int unsigned IRQ_WIDTH = 8;

  // 3-bit level number to one-hot vector
  function automatic logic [IRQ_WIDTH-1:0] num2bit(input logic [2:0] num);
    return IRQ_WIDTH'(1) << num;
  endfunction

  // One-hot (or any) vector to the number of its lowest set bit; 0 when empty
  function automatic logic [2:0] bit2num(input logic [IRQ_WIDTH-1:0] vec);
    logic [2:0] num;
    num = 3'd0;
    for (int i = IRQ_WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) num = 3'(i);
    end
    return num;
  endfunction

  // Rotate an 8-bit vector right by n positions
  function automatic logic [IRQ_WIDTH-1:0] rotate_right(input logic [IRQ_WIDTH-1:0] vec,
                                                       input logic [2:0] n);
    logic [2*IRQ_WIDTH-1:0] dbl;
    dbl = {vec, vec} >> n;
    return dbl[IRQ_WIDTH-1:0];
  endfunction

  // Rotate an 8-bit vector left by n positions
  function automatic logic [IRQ_WIDTH-1:0] rotate_left(input logic [IRQ_WIDTH-1:0] vec,
                                                      input logic [2:0] n);
    logic [2*IRQ_WIDTH-1:0] dbl;
    dbl = {vec, vec} << n;
    return dbl[2*IRQ_WIDTH-1:IRQ_WIDTH];
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating-priority, fully nested winner selection against the in-service register.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [IRQ_WIDTH-1:0] pending,
  input  logic [IRQ_WIDTH-1:0] in_service_register,
  input  logic [2:0]           priority_rotate,
  output logic [IRQ_WIDTH-1:0] candidate
);

  logic [2:0]           rot_amt;
  logic [IRQ_WIDTH-1:0] pend_rot;
  logic [IRQ_WIDTH-1:0] isr_rot;
  logic [2:0]           win_num;
  logic [2:0]           isr_num;

  // Rotate so the highest-priority level sits at bit 0, pick lowest bits, rotate back
  always_comb begin
    rot_amt   = 3'(priority_rotate + 3'd1);
    pend_rot  = rotate_right(pending, rot_amt);
    isr_rot   = rotate_right(in_service_register, rot_amt);
    win_num   = bit2num(pend_rot);
    isr_num   = bit2num(isr_rot);
    candidate = '0;
    if ((pend_rot != '0) && ((isr_rot == '0) || (win_num < isr_num))) begin
      candidate = rotate_left(num2bit(win_num), rot_amt);
    end
  end

endmodule

// File: rtl/pic_interrupt_request_resolver.sv
// IR pin sampling, IRR (edge/level), masking and priority resolution feeding a
// registered one-hot interrupt vector. Define IRQ_SYNC_EN to add a two-flop
// synchronizer on every IR pin (adds two cycles of pin-to-interrupt latency).
module pic_interrupt_request_resolver
  import pic_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IRQ_WIDTH-1:0] interrupt_request_pin,
  input  logic                 level_or_edge_triggered_config,
  input  logic                 freeze,
  input  logic [IRQ_WIDTH-1:0] clear_interrupt_request,
  input  logic [IRQ_WIDTH-1:0] interrupt_mask,
  input  logic [2:0]           priority_rotate,
  input  logic [IRQ_WIDTH-1:0] in_service_register,
  output logic [IRQ_WIDTH-1:0] interrupt_request_register,
  output logic [IRQ_WIDTH-1:0] interrupt
);

  logic [IRQ_WIDTH-1:0] pin_sample;
  logic [IRQ_WIDTH-1:0] prev_sample_q, prev_sample_d;
  logic [IRQ_WIDTH-1:0] irr_q, irr_d;
  logic [IRQ_WIDTH-1:0] interrupt_q, interrupt_d;
  logic [IRQ_WIDTH-1:0] pending;
  logic [IRQ_WIDTH-1:0] candidate;

`ifdef IRQ_SYNC_EN
  logic [IRQ_WIDTH-1:0] sync1_q, sync1_d;
  logic [IRQ_WIDTH-1:0] sync2_q, sync2_d;

  // Two-stage synchronizer chain for asynchronous IR sources
  always_comb begin
    sync1_d = interrupt_request_pin;
    sync2_d = sync1_q;
  end

  // Synchronizer flops, cleared at reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign pin_sample = sync2_q;
`else
  assign pin_sample = interrupt_request_pin;
`endif

  // Previous sample tracks the pins every cycle, independent of freeze
  always_comb prev_sample_d = pin_sample;

  // IRR next state: clear beats freeze beats edge/level capture
  always_comb begin
    irr_d = irr_q;
    for (int i = 0; i < IRQ_WIDTH; i++) begin
      if (clear_interrupt_request[i]) begin
        irr_d[i] = 1'b0;
      end else if (freeze) begin
        irr_d[i] = irr_q[i];
      end else if (level_or_edge_triggered_config) begin
        irr_d[i] = pin_sample[i];
      end else if (!prev_sample_q[i] && pin_sample[i]) begin
        irr_d[i] = 1'b1;
      end
    end
  end

  assign pending = irr_q & ~interrupt_mask;

  pic_priority_resolver u_priority_resolver (
    .pending             (pending),
    .in_service_register (in_service_register),
    .priority_rotate     (priority_rotate),
    .candidate           (candidate)
  );

  // Output vector updates with the resolver result unless an acknowledge is underway
  always_comb interrupt_d = freeze ? interrupt_q : candidate;

  // State registers; prev sample resets high so a pin already high needs a fresh edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_sample_q <= '1;
      irr_q         <= '0;
      interrupt_q   <= '0;
    end else begin
      prev_sample_q <= prev_sample_d;
      irr_q         <= irr_d;
      interrupt_q   <= interrupt_d;
    end
  end

  assign interrupt_request_register = irr_q;
  assign interrupt                  = interrupt_q;

endmodule

// File: tb/tb_pic_interrupt_request_resolver.sv
// Scoreboard bench for pic_interrupt_request_resolver: stimulus pushes expected
// IRR/interrupt values from a behavioural model, a monitor pops and compares.
module tb_pic_interrupt_request_resolver;

  typedef struct packed {
    logic [7:0] irr;
    logic [7:0] intr;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic [7:0] interrupt_request_pin;
  logic       level_or_edge_triggered_config;
  logic       freeze;
  logic [7:0] clear_interrupt_request;
  logic [7:0] interrupt_mask;
  logic [2:0] priority_rotate;
  logic [7:0] in_service_register;
  logic [7:0] interrupt_request_register;
  logic [7:0] interrupt;

  pic_interrupt_request_resolver dut (
    .clk                            (clk),
    .reset_n                        (reset_n),
    .interrupt_request_pin          (interrupt_request_pin),
    .level_or_edge_triggered_config (level_or_edge_triggered_config),
    .freeze                         (freeze),
    .clear_interrupt_request        (clear_interrupt_request),
    .interrupt_mask                 (interrupt_mask),
    .priority_rotate                (priority_rotate),
    .in_service_register            (in_service_register),
    .interrupt_request_register     (interrupt_request_register),
    .interrupt                      (interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Stimulus settings applied at the next step
  logic [7:0] s_pin, s_clr, s_mask, s_isr;
  logic       s_ltim, s_frz;
  logic [2:0] s_rot;

  // Behavioural model state
  logic [7:0] m_irr, m_int, m_prev, m_s1, m_s2;

  // Winner by walking levels from highest to lowest priority
  function automatic logic [7:0] ref_candidate(input logic [7:0] irr, input logic [7:0] mask,
                                               input logic [7:0] isr, input logic [2:0] rot);
    int win_rank, win_lvl, top_rank;
    logic [7:0] one;
    win_rank = -1;
    win_lvl  = 0;
    top_rank = -1;
    for (int k = 0; k < 8; k++) begin
      int lvl;
      lvl = (int'(rot) + 1 + k) % 8;
      if (win_rank < 0 && irr[lvl] && !mask[lvl]) begin
        win_rank = k;
        win_lvl  = lvl;
      end
      if (top_rank < 0 && isr[lvl]) top_rank = k;
    end
    if (win_rank < 0) return 8'h00;
    if (top_rank >= 0 && top_rank <= win_rank) return 8'h00;
    one = 8'h01;
    return one << win_lvl;
  endfunction

  task automatic model_reset();
    m_irr  = 8'h00;
    m_int  = 8'h00;
    m_prev = 8'hFF;
    m_s1   = 8'h00;
    m_s2   = 8'h00;
  endtask

  // Drive the current settings and predict the state after the coming posedge
  task automatic apply();
    logic [7:0] sample, nirr, cand;
    exp_t e;
    interrupt_request_pin          = s_pin;
    level_or_edge_triggered_config = s_ltim;
    freeze                         = s_frz;
    clear_interrupt_request        = s_clr;
    interrupt_mask                 = s_mask;
    priority_rotate                = s_rot;
    in_service_register            = s_isr;
`ifdef IRQ_SYNC_EN
    sample = m_s2;
    m_s2   = m_s1;
    m_s1   = s_pin;
`else
    sample = s_pin;
`endif
    cand = ref_candidate(m_irr, s_mask, s_isr, s_rot);
    for (int i = 0; i < 8; i++) begin
      if (s_clr[i])      nirr[i] = 1'b0;
      else if (s_frz)    nirr[i] = m_irr[i];
      else if (s_ltim)   nirr[i] = sample[i];
      else               nirr[i] = m_irr[i] | (~m_prev[i] & sample[i]);
    end
    if (!s_frz) m_int = cand;
    m_irr  = nirr;
    m_prev = sample;
    e.irr  = m_irr;
    e.intr = m_int;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      apply();
    end
  endtask

  // Monitor: compares after every clock edge and on asynchronous reset assertion
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge reset_n);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (interrupt_request_register !== e.irr) begin
          errors++;
          $display("FAIL irr @%0t: got %h expected %h", $time, interrupt_request_register, e.irr);
        end
        checks++;
        if (interrupt !== e.intr) begin
          errors++;
          $display("FAIL interrupt @%0t: got %h expected %h", $time, interrupt, e.intr);
        end
      end
    end
  end

  // Assert reset asynchronously between edges and expect zeroed outputs right away
  task automatic async_reset();
    exp_t e;
    @(posedge clk);
    #3;
    e.irr  = 8'h00;
    e.intr = 8'h00;
    exp_q.push_back(e);
    reset_n = 1'b0;
    model_reset();
    #20;
    @(negedge clk);
    reset_n = 1'b1;
    apply();
  endtask

  initial begin
    s_pin = 8'h00; s_clr = 8'h00; s_mask = 8'h00; s_isr = 8'h00;
    s_ltim = 1'b0; s_frz = 1'b0; s_rot = 3'd7;
    interrupt_request_pin          = 8'h00;
    level_or_edge_triggered_config = 1'b0;
    freeze                         = 1'b0;
    clear_interrupt_request        = 8'h00;
    interrupt_mask                 = 8'h00;
    priority_rotate                = 3'd7;
    in_service_register            = 8'h00;
    reset_n = 1'b1;
    model_reset();
    #2;
    async_reset();

    // Edge capture on IR3, then clear while pin stays high
    step(4);
    s_pin = 8'h08; step(4);
    s_clr = 8'h08; step(1);
    s_clr = 8'h00; step(3);

    // Rotation: IR1 vs IR5
    s_pin = 8'h00; step(2);
    s_pin = 8'h22; step(4);
    s_rot = 3'd1;  step(2);
    s_rot = 3'd7;  step(1);

    // Masking and in-service nesting
    s_mask = 8'h02; step(2);
    s_mask = 8'h00; s_clr = 8'h20; step(1);
    s_clr = 8'h00; s_isr = 8'h01; step(2);
    s_isr = 8'h04; step(2);

    // Freeze blocks IRR sets and output updates; no edge afterwards
    s_frz = 1'b1; s_pin = 8'h62; s_isr = 8'h00; step(3);
    s_frz = 1'b0; step(3);
    s_clr = 8'hFF; s_pin = 8'h00; step(1);
    s_clr = 8'h00; step(2);

    // Level mode follow, then same-cycle clear and level-high
    s_ltim = 1'b1;
    s_pin = 8'h10; step(3);
    s_pin = 8'h00; step(3);
    s_pin = 8'h10; step(2);
    s_clr = 8'h10; step(1);
    s_clr = 8'h00; step(2);

    // Async reset with IRR full, then pins held high must not capture
    s_pin = 8'hFF; step(3);
    s_ltim = 1'b0;
    async_reset();
    step(3);
    s_pin = 8'h00; step(2);
    s_pin = 8'hFF; step(3);
    s_clr = 8'hFF; step(1);
    s_clr = 8'h00; step(1);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) s_pin = 8'($urandom);
      s_clr  = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      s_frz  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) s_mask = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 9) == 0) s_rot  = 3'($urandom);
      if ($urandom_range(0, 5) == 0) s_isr  = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'(8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) s_ltim = ~s_ltim;
      step(1);
    end

    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
